context_actag_table: RTL and testbench

CONTEXT_ACTAG_TABLE -- requirements
Module: context_actag_table

---
 rtl/context_actag_table_pkg.sv | 24 ++
 rtl/context_actag_table_cnt.sv | 44 ++++
 rtl/context_actag_table.sv | 198 +++++++++++++++++++
 tb/tb_context_actag_table.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/context_actag_table_pkg.sv
// Shared definitions for the acTag context table: assign_actag opcode,
// controller state encoding and the PASID base/offset mask helper.
package context_actag_table_pkg;

  localparam logic [7:0] OPC_ASSIGN_ACTAG = 8'h50;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // Bits set in the mask come from the PASID base; cleared bits come from the context.
  function automatic logic [19:0] pasid_mask(input logic [4:0] len);
    logic [19:0] m;
    if (len > 5'd19) begin
      m = 20'h00000;
    end else begin
      m = 20'hFFFFF << len;
    end
    return m;
  endfunction

endpackage

// File: rtl/context_actag_table_cnt.sv
// Per-slot outstanding-command counter: saturates at both ends and flags
// a completion that arrives while the count is already zero.
module ctx_outstanding_cnt
  import context_actag_table_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full,
  output logic underflow
);

  logic [CNT_W-1:0] count_r;
  logic             zero_s;
  logic             full_s;

  assign zero_s    = (count_r == '0);
  assign full_s    = &count_r;
  assign zero      = zero_s;
  assign full      = full_s;
  assign underflow = dec & ~inc & zero_s;

  // Outstanding count; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (!full_s) count_r <= count_r + CNT_W'(1);
        end
        2'b01: begin
          if (!zero_s) count_r <= count_r - CNT_W'(1);
        end
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/context_actag_table.sv
// acTag slot table: hits are granted combinationally; a miss evicts a slot,
// waits for its outstanding commands to drain and issues assign_actag.
module context_actag_table
  import context_actag_table_pkg::*;
#(
  parameter int  NUM_SLOTS = 4,
  parameter int  CTX_W     = 9,
  parameter int  CNT_W     = 6,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       cfg_actag_base,
  input  logic [19:0]       cfg_pasid_base,
  input  logic [4:0]        cfg_pasid_length,
  input  logic              req_valid,
  input  logic [CTX_W-1:0]  req_ctx,
  output logic              req_ready,
  output logic [SLOT_W-1:0] req_slot,
  output logic [11:0]       req_actag,
  input  logic              cpl_valid,
  input  logic [SLOT_W-1:0] cpl_slot,
  input  logic              ctx_flush,
  output logic              tlx_cmd_valid,
  input  logic              tlx_cmd_ready,
  output logic [7:0]        tlx_cmd_opcode,
  output logic [19:0]       tlx_cmd_pasid,
  output logic [11:0]       tlx_cmd_actag,
  output logic              cnt_err
);

  state_e             state_r, state_nx_s;
  logic [NUM_SLOTS-1:0] valid_r;
  logic [CTX_W-1:0]   tag_r [NUM_SLOTS];
  logic [SLOT_W-1:0]  rr_ptr_r;
  logic               flush_pend_r;
  logic [CTX_W-1:0]   ctx_r;
  logic [SLOT_W-1:0]  victim_r;
  logic               victim_was_valid_r;
  logic               tlx_valid_r;
  logic [7:0]         tlx_opcode_r;
  logic [19:0]        tlx_pasid_r;
  logic [11:0]        tlx_actag_r;
  logic               cnt_err_r;

  logic [NUM_SLOTS-1:0] inc_s, dec_s, zero_s, full_s, underflow_s;
  logic               hit_any_s, free_any_s;
  logic [SLOT_W-1:0]  hit_idx_s, free_idx_s, victim_sel_s, rr_next_s;
  logic               flush_now_s, req_ready_s;
  logic               start_s, go_s, hs_s, flush_apply_s;
  logic [19:0]        mask_s;

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
      assign inc_s[g] = req_ready_s && (hit_idx_s == SLOT_W'(g));
      assign dec_s[g] = cpl_valid && (cpl_slot == SLOT_W'(g));
      ctx_outstanding_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc_s[g]),
        .dec       (dec_s[g]),
        .zero      (zero_s[g]),
        .full      (full_s[g]),
        .underflow (underflow_s[g])
      );
    end
  endgenerate

  // Lowest-index hit and lowest-index free slot.
  always_comb begin
    hit_any_s  = 1'b0;
    hit_idx_s  = '0;
    free_any_s = 1'b0;
    free_idx_s = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_r[i] && (tag_r[i] == req_ctx)) begin
        hit_any_s = 1'b1;
        hit_idx_s = SLOT_W'(i);
      end else begin
        hit_any_s = hit_any_s;
      end
      if (!valid_r[i]) begin
        free_any_s = 1'b1;
        free_idx_s = SLOT_W'(i);
      end else begin
        free_any_s = free_any_s;
      end
    end
  end

  assign victim_sel_s = free_any_s ? free_idx_s : rr_ptr_r;
  assign rr_next_s    = (victim_r == SLOT_W'(NUM_SLOTS - 1)) ? '0 : victim_r + SLOT_W'(1);
  assign flush_now_s  = ctx_flush | flush_pend_r;
  assign mask_s       = pasid_mask(cfg_pasid_length);
  // A pending flush blocks grants so nothing is counted against a slot being invalidated.
  assign req_ready_s  = (state_r == ST_IDLE) && req_valid && hit_any_s &&
                        !full_s[hit_idx_s] && !flush_now_s;

  assign req_ready      = req_ready_s;
  assign req_slot       = hit_idx_s;
  assign req_actag      = cfg_actag_base + 12'(hit_idx_s);
  assign tlx_cmd_valid  = tlx_valid_r;
  assign tlx_cmd_opcode = tlx_opcode_r;
  assign tlx_cmd_pasid  = tlx_pasid_r;
  assign tlx_cmd_actag  = tlx_actag_r;
  assign cnt_err        = cnt_err_r;

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state and one-cycle action strobes.
  always_comb begin
    state_nx_s    = state_r;
    start_s       = 1'b0;
    go_s          = 1'b0;
    hs_s          = 1'b0;
    flush_apply_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush_now_s) begin
          flush_apply_s = 1'b1;
        end else if (req_valid && !hit_any_s) begin
          start_s    = 1'b1;
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // An invalid victim may still carry stale counts; it is reused at once.
        if (!victim_was_valid_r || zero_s[victim_r]) begin
          go_s       = 1'b1;
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_ISSUE: begin
        if (tlx_cmd_ready) begin
          hs_s       = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Slot table, victim bookkeeping, assign_actag command and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r            <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) tag_r[i] <= '0;
      rr_ptr_r           <= '0;
      flush_pend_r       <= 1'b0;
      ctx_r              <= '0;
      victim_r           <= '0;
      victim_was_valid_r <= 1'b0;
      tlx_valid_r        <= 1'b0;
      tlx_opcode_r       <= 8'h00;
      tlx_pasid_r        <= 20'h00000;
      tlx_actag_r        <= 12'h000;
      cnt_err_r          <= 1'b0;
    end else begin
      if (start_s) begin
        ctx_r              <= req_ctx;
        victim_r           <= victim_sel_s;
        victim_was_valid_r <= !free_any_s;
      end
      if (go_s) begin
        tlx_valid_r  <= 1'b1;
        tlx_opcode_r <= OPC_ASSIGN_ACTAG;
        tlx_actag_r  <= cfg_actag_base + 12'(victim_r);
        tlx_pasid_r  <= (cfg_pasid_base & mask_s) | (20'(ctx_r) & ~mask_s);
      end else if (hs_s) begin
        tlx_valid_r <= 1'b0;
      end
      if (hs_s) begin
        valid_r[victim_r] <= 1'b1;
        tag_r[victim_r]   <= ctx_r;
        if (victim_was_valid_r) rr_ptr_r <= rr_next_s;
      end
      if (flush_apply_s) begin
        valid_r      <= '0;
        flush_pend_r <= 1'b0;
      end else if (ctx_flush && (state_r != ST_IDLE)) begin
        flush_pend_r <= 1'b1;
      end
      cnt_err_r <= cnt_err_r | (|underflow_s);
    end
  end

endmodule

// File: tb/tb_context_actag_table.sv
// Directed bench for context_actag_table: assign, hit, eviction drain,
// TLX backpressure, flush during ISSUE, counter underflow and reset.
module tb_context_actag_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cfg_actag_base;
  logic [19:0] cfg_pasid_base;
  logic [4:0]  cfg_pasid_length;
  logic        req_valid;
  logic [8:0]  req_ctx;
  logic        req_ready;
  logic [1:0]  req_slot;
  logic [11:0] req_actag;
  logic        cpl_valid;
  logic [1:0]  cpl_slot;
  logic        ctx_flush;
  logic        tlx_cmd_valid;
  logic        tlx_cmd_ready;
  logic [7:0]  tlx_cmd_opcode;
  logic [19:0] tlx_cmd_pasid;
  logic [11:0] tlx_cmd_actag;
  logic        cnt_err;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  context_actag_table dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_actag_base   (cfg_actag_base),
    .cfg_pasid_base   (cfg_pasid_base),
    .cfg_pasid_length (cfg_pasid_length),
    .req_valid        (req_valid),
    .req_ctx          (req_ctx),
    .req_ready        (req_ready),
    .req_slot         (req_slot),
    .req_actag        (req_actag),
    .cpl_valid        (cpl_valid),
    .cpl_slot         (cpl_slot),
    .ctx_flush        (ctx_flush),
    .tlx_cmd_valid    (tlx_cmd_valid),
    .tlx_cmd_ready    (tlx_cmd_ready),
    .tlx_cmd_opcode   (tlx_cmd_opcode),
    .tlx_cmd_pasid    (tlx_cmd_pasid),
    .tlx_cmd_actag    (tlx_cmd_actag),
    .cnt_err          (cnt_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_ctx = 9'd0; cpl_valid = 1'b0;
    cpl_slot = 2'd0; ctx_flush = 1'b0; tlx_cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_req_ready", req_ready, 1'b0);
    check_val("rst_tlx_valid", tlx_cmd_valid, 1'b0);
    check_val("rst_cnt_err", cnt_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic complete(input logic [1:0] slot, input int count);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      cpl_valid = 1'b1; cpl_slot = slot;
    end
    @(negedge clk);
    cpl_valid = 1'b0;
  endtask

  task automatic wait_tlx(input string tag);
    int n;
    n = 0;
    #1;
    while (!tlx_cmd_valid && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check_val({tag, "_tlx_timeout"}, n < 40, 1'b1);
  endtask

  task automatic request(input logic [8:0] ctx, input logic exp_assign, input logic [19:0] exp_pasid,
                         input logic [11:0] exp_actag, input logic [1:0] exp_slot, input string tag);
    int   n;
    logic saw;
    n = 0; saw = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_ctx = ctx; tlx_cmd_ready = 1'b1;
    #1;
    while (!req_ready && n < 40) begin
      if (tlx_cmd_valid) begin
        saw = 1'b1;
        check_val({tag, "_opcode"}, tlx_cmd_opcode, 8'h50);
        check_val({tag, "_pasid"}, tlx_cmd_pasid, exp_pasid);
        check_val({tag, "_tlx_actag"}, tlx_cmd_actag, exp_actag);
      end
      @(negedge clk); #1; n++;
    end
    check_val({tag, "_ready"}, req_ready, 1'b1);
    check_val({tag, "_assign_seen"}, saw, exp_assign);
    check_val({tag, "_slot"}, req_slot, exp_slot);
    check_val({tag, "_req_actag"}, req_actag, exp_actag);
    @(posedge clk); #1;
    req_valid = 1'b0; tlx_cmd_ready = 1'b0;
  endtask

  initial begin
    int hs;
    int n;
    logic [11:0] last_actag;
    logic [19:0] last_pasid;
    cfg_actag_base = 12'h010; cfg_pasid_base = 20'hAB000; cfg_pasid_length = 5'd9;

    // First assign after reset, then the request hits.
    do_reset();
    request(9'd5, 1'b1, 20'hAB005, 12'h010, 2'd0, "basic");

    // Fill all four slots, then hit slot 0 twice (counter 3).
    do_reset();
    request(9'd1, 1'b1, 20'hAB001, 12'h010, 2'd0, "fill1");
    request(9'd2, 1'b1, 20'hAB002, 12'h011, 2'd1, "fill2");
    request(9'd3, 1'b1, 20'hAB003, 12'h012, 2'd2, "fill3");
    request(9'd4, 1'b1, 20'hAB004, 12'h013, 2'd3, "fill4");
    request(9'd1, 1'b0, 20'hAB001, 12'h010, 2'd0, "hit1a");
    request(9'd1, 1'b0, 20'hAB001, 12'h010, 2'd0, "hit1b");

    // Eviction of slot 0 waits for its three completions.
    @(negedge clk);
    req_valid = 1'b1; req_ctx = 9'd7; tlx_cmd_ready = 1'b0;
    repeat (5) begin
      #1;
      check_val("drain_tlx_valid", tlx_cmd_valid, 1'b0);
      check_val("drain_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      cpl_valid = 1'b1; cpl_slot = 2'd0;
      #1;
      check_val("drain_cpl_tlx_valid", tlx_cmd_valid, 1'b0);
      @(negedge clk);
    end
    cpl_valid = 1'b0;
    wait_tlx("evict");
    // Backpressure: command held stable for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      check_val("bp_valid", tlx_cmd_valid, 1'b1);
      check_val("bp_opcode", tlx_cmd_opcode, 8'h50);
      check_val("bp_actag", tlx_cmd_actag, 12'h010);
      check_val("bp_pasid", tlx_cmd_pasid, 20'hAB007);
      check_val("bp_req_ready", req_ready, 1'b0);
      @(negedge clk); #1;
    end
    tlx_cmd_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check_val("evict_ready", req_ready, 1'b1);
    check_val("evict_slot", req_slot, 2'd0);
    check_val("evict_actag", req_actag, 12'h010);
    @(posedge clk); #1;
    req_valid = 1'b0; tlx_cmd_ready = 1'b0;

    // Round-robin pointer now at 1: next eviction uses slot 1.
    complete(2'd1, 1);
    request(9'd8, 1'b1, 20'hAB008, 12'h011, 2'd1, "rr");

    // Flush during ISSUE: assignment finishes, table empties, ctx 9 re-assigned.
    complete(2'd2, 1);
    @(negedge clk);
    req_valid = 1'b1; req_ctx = 9'd9; tlx_cmd_ready = 1'b0;
    wait_tlx("flush");
    check_val("flush_first_actag", tlx_cmd_actag, 12'h012);
    @(negedge clk);
    ctx_flush = 1'b1;
    @(negedge clk);
    ctx_flush = 1'b0; tlx_cmd_ready = 1'b1;
    hs = 0; n = 0; last_actag = 12'h000; last_pasid = 20'h00000;
    #1;
    while (!req_ready && n < 40) begin
      if (tlx_cmd_valid && tlx_cmd_ready) begin
        hs++; last_actag = tlx_cmd_actag; last_pasid = tlx_cmd_pasid;
      end
      @(negedge clk); #1; n++;
    end
    check_val("flush_handshakes", hs, 2);
    check_val("flush_second_actag", last_actag, 12'h010);
    check_val("flush_second_pasid", last_pasid, 20'hAB009);
    check_val("flush_ready", req_ready, 1'b1);
    check_val("flush_slot", req_slot, 2'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; tlx_cmd_ready = 1'b0;
    // ctx 7 was flushed: it misses and takes the lowest invalid slot.
    request(9'd7, 1'b1, 20'hAB007, 12'h011, 2'd1, "post_flush");

    // Completion on an idle slot sets the sticky error.
    @(negedge clk); #1;
    check_val("err_before", cnt_err, 1'b0);
    complete(2'd2, 1);
    repeat (3) begin
      #1;
      check_val("err_sticky", cnt_err, 1'b1);
      @(negedge clk);
    end

    // Reset while an assign_actag is pending abandons it.
    req_valid = 1'b1; req_ctx = 9'd10; tlx_cmd_ready = 1'b0;
    wait_tlx("rst_issue");
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check_val("rst_mid_tlx_valid", tlx_cmd_valid, 1'b0);
    check_val("rst_mid_cnt_err", cnt_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      #1;
      check_val("after_rst_tlx_valid", tlx_cmd_valid, 1'b0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
